fetch_buffer: RTL
=================

Name: fetch_buffer

Overview:
- Small instruction queue directly downstream of instr_fetch. It decouples fetch from the decode stage.
- Captures each fetched {addr, instr} pair and presents entries in order on a valid/ready interface to decode.
- Generates stall_en back to pc/instr_fetch when it cannot accept more words.
- Supports a synchronous flush so a redirect discards all buffered words.

Parameters:
- ADDR_W, 9, width of instruction address; matches the pc address register.
- DATA_W, 32, width of the instruction word.
- DEPTH, 4, number of entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous discard of all entries and of any same-cycle push.
- in_valid  input  1  instr_fetch presents a word this cycle.
- in_ready  output  1  buffer can accept a word this cycle.
- in_addr  input  ADDR_W  address of the presented word.
- in_instr  input  DATA_W  presented instruction word.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  decode consumes the head entry this cycle.
- out_addr  output  ADDR_W  address of the head entry.
- out_instr  output  DATA_W  instruction of the head entry.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- stall_en  output  1  stall request to pc/instr_fetch.

Behaviour:
- Storage: circular array of DEPTH entries, each {addr, instr}.
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy counter is held separately; full/empty are derived from it, never from pointer comparison.
- Reset: rst_n low asynchronously clears wr_ptr, rd_ptr and count to 0. While reset is held and immediately after:
  - out_valid=0, in_ready=1, stall_en=0, count=0
  - out_addr=0, out_instr=0
  - Storage array contents are not reset.
- push = in_valid & in_ready & ~flush.
- pop = out_valid & out_ready & ~flush.
- in_ready = (count != DEPTH). It depends only on registered state. There is no combinational path from out_ready to in_ready, so a push into a full buffer is refused even when a pop happens in the same cycle.
- out_valid = (count != 0).
- out_addr and out_instr are driven from the entry at rd_ptr. When count==0 they hold the last value read, or 0 after reset.
- Latency:
  - A word pushed in cycle N is visible on out_* with out_valid=1 from cycle N+1.
  - There is no same-cycle bypass from input to output when the buffer is empty.
- Push only: entry written at wr_ptr, wr_ptr+1, count+1.
- Pop only: rd_ptr+1, count-1.
- Push and pop together (possible when 0<count<DEPTH): both pointers advance, count is unchanged, and order is preserved.
- Flush (highest priority after reset):
  - Next cycle: wr_ptr=rd_ptr=0, count=0, out_valid=0, stall_en=0.
  - A push or pop presented in the same cycle as flush is ignored.
- stall_en = (count >= DEPTH-1).
  - It is driven from registered count, so it asserts one entry early.
  - This covers the one-cycle reaction delay of pc: a word already in flight from instr_fetch can still be absorbed.
- Overrun: in_valid=1 while in_ready=0 is not an error. The word is simply not taken, and the upstream stage must hold it.
- Order guarantee: words leave in exactly the order they were accepted. No entry is duplicated or dropped except by flush.
- Reset asserted mid-operation: all entries are lost immediately and the outputs take their reset values without waiting for a clock edge.

Test Plan:
1. Reset then idle: hold rst_n=0 for 3 cycles, release -> count=0, out_valid=0, in_ready=1, stall_en=0, out_addr=0.
2. Single pass-through:
   - Stimulus: push addr=5, instr=32'hDEADBEEF in cycle N with out_ready=0.
   - Response: at N+1 out_valid=1, out_addr=5, out_instr=DEADBEEF, count=1.
   - Then out_ready=1 for one cycle -> count=0, out_valid=0.
3. Fill and stall (DEPTH=4):
   - Stimulus: push addr 0,1,2,3 on consecutive cycles with out_ready=0.
   - Response: stall_en rises when count=3; after the 4th push count=4, in_ready=0.
   - A 5th word (addr 4) held on in_valid is not accepted, and count stays 4.
4. Full with simultaneous pop:
   - Stimulus: from full, out_ready=1 and in_valid=1 (addr 4).
   - Response: pop of addr 0 only; count=3, in_ready=1 next cycle.
   - Addr 4 is accepted the following cycle and later drains in order after addr 3.
5. Streaming with wrap:
   - Stimulus: continuous push of addr 0..13 with out_ready=1 every cycle.
   - Response: out_addr sequence 0..13 with 1-cycle latency, count stays at 1, pointers wrap at least 3 times, no gaps or duplicates.
6. Flush and reset mid-operation:
   - Flush stimulus: with count=3, assert flush together with in_valid=1 (addr 9) and out_ready=1.
   - Flush response: next cycle count=0, out_valid=0; addr 9 never appears on the output.
   - Reset stimulus: refill to count=2, then pulse rst_n low between clock edges.
   - Reset response: count=0 and out_valid=0 immediately, before the next rising edge.

Source files
------------

// File: rtl/fetch_buffer.sv
// fetch_buffer: in-order {addr, instr} queue between instr_fetch and decode.
// Latency: a word pushed in cycle N appears on out_* in cycle N+1 (no empty bypass).
// Backpressure: in_ready drops only when full (registered count); stall_en rises one entry early.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   flush                   synchronous discard of all entries and any same-cycle push/pop
//   in_valid/in_ready       upstream handshake carrying in_addr/in_instr
//   out_valid/out_ready     downstream handshake carrying out_addr/out_instr (head entry)
//   count                   occupancy 0..DEPTH
//   stall_en                asserted when count >= DEPTH-1
module fetch_buffer #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_addr,
  input  logic [DATA_W-1:0]          in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_W-1:0]          out_addr,
  output logic [DATA_W-1:0]          out_instr,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       stall_en
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - 1);

  // Storage is deliberately not reset; only pointers, count and the hold
  // registers are.
  logic [ADDR_W-1:0] addr_mem  [DEPTH];
  logic [DATA_W-1:0] instr_mem [DEPTH];

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt_q;
  logic [ADDR_W-1:0] hold_addr_q;
  logic [DATA_W-1:0] hold_instr_q;

  logic push;
  logic pop;

  // Full/empty come from the occupancy counter only. in_ready has no path
  // from out_ready, so a full buffer refuses a push even while popping.
  assign in_ready  = (cnt_q != FULL_CNT);
  assign out_valid = (cnt_q != '0);
  assign stall_en  = (cnt_q >= STALL_CNT);
  assign count     = cnt_q;

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr]  <= in_addr;
      instr_mem[wr_ptr] <= in_instr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (pop && !push) cnt_q <= cnt_q - CW'(1);
    end
  end

  // Track the head while the buffer is non-empty so that an empty buffer
  // keeps presenting the last word decode saw (0 straight out of reset)
  // instead of unreset storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_addr_q  <= '0;
      hold_instr_q <= '0;
    end else if (out_valid) begin
      hold_addr_q  <= addr_mem[rd_ptr];
      hold_instr_q <= instr_mem[rd_ptr];
    end
  end

  assign out_addr  = out_valid ? addr_mem[rd_ptr]  : hold_addr_q;
  assign out_instr = out_valid ? instr_mem[rd_ptr] : hold_instr_q;

endmodule
